// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer producing the datapath's one-hot control strobes.
// Execute-phase strobes come from IR[31:27] in T3 and from a copy of it latched at the end of T3.
module control_unit (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] IR,
    output logic        PCout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        InPortOut,
    output logic        MARin,
    output logic        Zin,
    output logic        PCin,
    output logic        MDRin,
    output logic        IRin,
    output logic        Yin,
    output logic        Rin,
    output logic        OutPort,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rout,
    output logic        IncPC,
    output logic        Read,
    output logic        ADD,
    output logic        SUB,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        run,
    output logic        illegal,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        ST_RST  = 3'd0,
        ST_T0   = 3'd1,
        ST_T1   = 3'd2,
        ST_T2   = 3'd3,
        ST_T3   = 3'd4,
        ST_T4   = 3'd5,
        ST_T5   = 3'd6,
        ST_HALT = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_ALU2 = 4'd0,
        C_ALU1 = 4'd1,
        C_IN   = 4'd2,
        C_OUT  = 4'd3,
        C_MFHI = 4'd4,
        C_MFLO = 4'd5,
        C_NOP  = 4'd6,
        C_HALT = 4'd7,
        C_ILL  = 4'd8
    } class_t;

    function automatic class_t op_class(input logic [4:0] op);
        class_t c;
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: c = C_ALU2;
            5'b10000, 5'b10001:                     c = C_ALU1;
            5'b10110:                               c = C_IN;
            5'b10111:                               c = C_OUT;
            5'b11000:                               c = C_MFHI;
            5'b11001:                               c = C_MFLO;
            5'b11010:                               c = C_NOP;
            5'b11011:                               c = C_HALT;
            default:                                c = C_ILL;
        endcase
        return c;
    endfunction

    // Bit order: {NOT, NEG, ROL, ROR, SHL, SHR, OR, AND, SUB, ADD}
    function automatic logic [9:0] alu_decode(input logic [4:0] op);
        logic [9:0] sel;
        case (op)
            5'b00011: sel = 10'b00_0000_0001;
            5'b00100: sel = 10'b00_0000_0010;
            5'b01001: sel = 10'b00_0000_0100;
            5'b01010: sel = 10'b00_0000_1000;
            5'b00101: sel = 10'b00_0001_0000;
            5'b00110: sel = 10'b00_0010_0000;
            5'b00111: sel = 10'b00_0100_0000;
            5'b01000: sel = 10'b00_1000_0000;
            5'b10000: sel = 10'b01_0000_0000;
            5'b10001: sel = 10'b10_0000_0000;
            default:  sel = 10'b00_0000_0000;
        endcase
        return sel;
    endfunction

    state_t      state_r;
    state_t      next_s;
    logic [4:0]  op_r;
    logic [4:0]  op_s;
    class_t      cls_s;
    logic [9:0]  alu_s;
    logic        done_s;
    logic [31:0] count_r;
    logic        unused_ir_s;

    assign unused_ir_s = ^IR[26:0];
    assign instr_count = count_r;
    assign cls_s       = op_class(op_s);

    // IR is only valid from T3 on, so T3 decodes it live and later states use the latched copy
    always_comb begin
        if (state_r == ST_T3) begin
            op_s = IR[31:27];
        end else begin
            op_s = op_r;
        end
    end

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r <= ST_RST;
        end else begin
            state_r <= next_s;
        end
    end

    // Opcode capture on the edge that ends T3
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            op_r <= 5'b00000;
        end else if (state_r == ST_T3) begin
            op_r <= IR[31:27];
        end else begin
            op_r <= op_r;
        end
    end

    // An instruction completes when an execute state hands back to T0 or into HALT
    always_comb begin
        if ((state_r == ST_T3 || state_r == ST_T4 || state_r == ST_T5) &&
            (next_s == ST_T0 || next_s == ST_HALT)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // Completed-instruction counter, wraps naturally at 32 bits
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count_r <= 32'd0;
        end else if (done_s) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Next-state and Moore strobe decode
    always_comb begin
        next_s    = state_r;
        PCout     = 1'b0;
        Zlowout   = 1'b0;
        MDRout    = 1'b0;
        HIout     = 1'b0;
        LOout     = 1'b0;
        InPortOut = 1'b0;
        MARin     = 1'b0;
        Zin       = 1'b0;
        PCin      = 1'b0;
        MDRin     = 1'b0;
        IRin      = 1'b0;
        Yin       = 1'b0;
        Rin       = 1'b0;
        OutPort   = 1'b0;
        Gra       = 1'b0;
        Grb       = 1'b0;
        Grc       = 1'b0;
        Rout      = 1'b0;
        IncPC     = 1'b0;
        Read      = 1'b0;
        run       = 1'b0;
        illegal   = 1'b0;
        alu_s     = 10'd0;
        case (state_r)
            ST_RST: begin
                next_s = ST_T0;
            end
            ST_T0: begin
                run    = 1'b1;
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zin    = 1'b1;
                next_s = ST_T1;
            end
            ST_T1: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
                next_s  = ST_T2;
            end
            ST_T2: begin
                run    = 1'b1;
                MDRout = 1'b1;
                IRin   = 1'b1;
                next_s = ST_T3;
            end
            ST_T3: begin
                run = 1'b1;
                case (cls_s)
                    C_ALU2: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        Yin    = 1'b1;
                        next_s = ST_T4;
                    end
                    C_ALU1: begin
                        Grb    = 1'b1;
                        Rout   = 1'b1;
                        alu_s  = alu_decode(op_s);
                        Zin    = 1'b1;
                        next_s = ST_T4;
                    end
                    C_IN: begin
                        InPortOut = 1'b1;
                        Gra       = 1'b1;
                        Rin       = 1'b1;
                        next_s    = ST_T0;
                    end
                    C_OUT: begin
                        Gra     = 1'b1;
                        Rout    = 1'b1;
                        OutPort = 1'b1;
                        next_s  = ST_T0;
                    end
                    C_MFHI: begin
                        HIout  = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                        next_s = ST_T0;
                    end
                    C_MFLO: begin
                        LOout  = 1'b1;
                        Gra    = 1'b1;
                        Rin    = 1'b1;
                        next_s = ST_T0;
                    end
                    C_NOP: begin
                        next_s = ST_T0;
                    end
                    C_HALT: begin
                        next_s = ST_HALT;
                    end
                    default: begin
                        illegal = 1'b1;
                        next_s  = ST_T0;
                    end
                endcase
            end
            ST_T4: begin
                run = 1'b1;
                case (cls_s)
                    C_ALU2: begin
                        Grc    = 1'b1;
                        Rout   = 1'b1;
                        alu_s  = alu_decode(op_s);
                        Zin    = 1'b1;
                        next_s = ST_T5;
                    end
                    C_ALU1: begin
                        Zlowout = 1'b1;
                        Gra     = 1'b1;
                        Rin     = 1'b1;
                        next_s  = ST_T0;
                    end
                    default: begin
                        next_s = ST_T0;
                    end
                endcase
            end
            ST_T5: begin
                run     = 1'b1;
                Zlowout = 1'b1;
                Gra     = 1'b1;
                Rin     = 1'b1;
                next_s  = ST_T0;
            end
            ST_HALT: begin
                next_s = ST_HALT;
            end
            default: begin
                next_s = ST_RST;
            end
        endcase
        {NOT, NEG, ROL, ROR, SHL, SHR, OR, AND, SUB, ADD} = alu_s;
    end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: every cycle's strobe set is compared with a per-opcode cycle table
// derived from the instruction-class descriptions, with randomized opcodes and IR garbage.
module tb_control_unit;

    localparam logic [31:0] M_PCOUT   = 32'd1 << 0;
    localparam logic [31:0] M_ZLOW    = 32'd1 << 1;
    localparam logic [31:0] M_MDROUT  = 32'd1 << 2;
    localparam logic [31:0] M_HIOUT   = 32'd1 << 3;
    localparam logic [31:0] M_LOOUT   = 32'd1 << 4;
    localparam logic [31:0] M_INPORT  = 32'd1 << 5;
    localparam logic [31:0] M_MARIN   = 32'd1 << 6;
    localparam logic [31:0] M_ZIN     = 32'd1 << 7;
    localparam logic [31:0] M_PCIN    = 32'd1 << 8;
    localparam logic [31:0] M_MDRIN   = 32'd1 << 9;
    localparam logic [31:0] M_IRIN    = 32'd1 << 10;
    localparam logic [31:0] M_YIN     = 32'd1 << 11;
    localparam logic [31:0] M_RIN     = 32'd1 << 12;
    localparam logic [31:0] M_OUTPORT = 32'd1 << 13;
    localparam logic [31:0] M_GRA     = 32'd1 << 14;
    localparam logic [31:0] M_GRB     = 32'd1 << 15;
    localparam logic [31:0] M_GRC     = 32'd1 << 16;
    localparam logic [31:0] M_ROUT    = 32'd1 << 17;
    localparam logic [31:0] M_INCPC   = 32'd1 << 18;
    localparam logic [31:0] M_READ    = 32'd1 << 19;
    localparam logic [31:0] M_ADD     = 32'd1 << 20;
    localparam logic [31:0] M_SUB     = 32'd1 << 21;
    localparam logic [31:0] M_AND     = 32'd1 << 22;
    localparam logic [31:0] M_OR      = 32'd1 << 23;
    localparam logic [31:0] M_SHR     = 32'd1 << 24;
    localparam logic [31:0] M_SHL     = 32'd1 << 25;
    localparam logic [31:0] M_ROR     = 32'd1 << 26;
    localparam logic [31:0] M_ROL     = 32'd1 << 27;
    localparam logic [31:0] M_NEG     = 32'd1 << 28;
    localparam logic [31:0] M_NOT     = 32'd1 << 29;
    localparam logic [31:0] M_RUN     = 32'd1 << 30;
    localparam logic [31:0] M_ILLEGAL = 32'd1 << 31;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic [31:0] ir = 32'd0;
    logic pc_out, zlow_out, mdr_out, hi_out, lo_out, inport_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, r_in, out_port;
    logic gra, grb, grc, r_out, inc_pc, rd;
    logic alu_add, alu_sub, alu_and, alu_or, alu_shr, alu_shl, alu_ror, alu_rol, alu_neg, alu_not;
    logic run, illegal;
    logic [31:0] instr_count;
    logic [31:0] obs;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_count = 32'd0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    assign obs = {illegal, run, alu_not, alu_neg, alu_rol, alu_ror, alu_shl, alu_shr,
                  alu_or, alu_and, alu_sub, alu_add, rd, inc_pc, r_out, grc, grb, gra,
                  out_port, r_in, y_in, ir_in, mdr_in, pc_in, z_in, mar_in,
                  inport_out, lo_out, hi_out, mdr_out, zlow_out, pc_out};

    control_unit dut (
        .clk(clk), .clear(clear), .IR(ir),
        .PCout(pc_out), .Zlowout(zlow_out), .MDRout(mdr_out), .HIout(hi_out),
        .LOout(lo_out), .InPortOut(inport_out),
        .MARin(mar_in), .Zin(z_in), .PCin(pc_in), .MDRin(mdr_in), .IRin(ir_in),
        .Yin(y_in), .Rin(r_in), .OutPort(out_port),
        .Gra(gra), .Grb(grb), .Grc(grc), .Rout(r_out), .IncPC(inc_pc), .Read(rd),
        .ADD(alu_add), .SUB(alu_sub), .AND(alu_and), .OR(alu_or), .SHR(alu_shr),
        .SHL(alu_shl), .ROR(alu_ror), .ROL(alu_rol), .NEG(alu_neg), .NOT(alu_not),
        .run(run), .illegal(illegal), .instr_count(instr_count)
    );

    function automatic logic [31:0] alu_mask(input logic [4:0] op);
        case (op)
            5'b00011: return M_ADD;
            5'b00100: return M_SUB;
            5'b00101: return M_SHR;
            5'b00110: return M_SHL;
            5'b00111: return M_ROR;
            5'b01000: return M_ROL;
            5'b01001: return M_AND;
            5'b01010: return M_OR;
            5'b10000: return M_NEG;
            5'b10001: return M_NOT;
            default:  return 32'd0;
        endcase
    endfunction

    // Expected strobe set for every cycle of one instruction, fetch included
    task automatic fill_exp(input logic [4:0] op);
        logic [31:0] a;
        a = alu_mask(op);
        exp_q.delete();
        exp_q.push_back(M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        exp_q.push_back(M_RUN | M_ZLOW | M_PCIN | M_READ | M_MDRIN);
        exp_q.push_back(M_RUN | M_MDROUT | M_IRIN);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
                exp_q.push_back(M_RUN | M_GRB | M_ROUT | M_YIN);
                exp_q.push_back(M_RUN | M_GRC | M_ROUT | a | M_ZIN);
                exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
            end
            5'b10000, 5'b10001: begin
                exp_q.push_back(M_RUN | M_GRB | M_ROUT | a | M_ZIN);
                exp_q.push_back(M_RUN | M_ZLOW | M_GRA | M_RIN);
            end
            5'b10110: exp_q.push_back(M_RUN | M_INPORT | M_GRA | M_RIN);
            5'b10111: exp_q.push_back(M_RUN | M_GRA | M_ROUT | M_OUTPORT);
            5'b11000: exp_q.push_back(M_RUN | M_HIOUT | M_GRA | M_RIN);
            5'b11001: exp_q.push_back(M_RUN | M_LOOUT | M_GRA | M_RIN);
            5'b11010, 5'b11011: exp_q.push_back(M_RUN);
            default:  exp_q.push_back(M_RUN | M_ILLEGAL);
        endcase
    endtask

    // Runs one instruction starting at a negedge in T0; stops early after cycle stop_at if >= 0
    task automatic run_instr(input logic [4:0] op, input int stop_at);
        int n;
        fill_exp(op);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (obs !== exp_q[i]) begin
                errors++;
                $display("FAIL strobes op=%b cyc=T%0d got=%h exp=%h", op, i, obs, exp_q[i]);
            end
            checks++;
            if (instr_count !== model_count) begin
                errors++;
                $display("FAIL instr_count op=%b cyc=T%0d got=%0d exp=%0d", op, i, instr_count, model_count);
            end
            if (i == stop_at) return;
            if (i == n - 1) model_count = model_count + 32'd1;
            if (i == 2) begin
                ir = {op, 27'($urandom)};
                @(negedge clk);
            end else if (i == 3) begin
                @(posedge clk);
                #1;
                ir = $urandom;
                @(negedge clk);
            end else begin
                ir = $urandom;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #1;
        clear = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs got=%h exp=%h", obs, 32'd0);
            end
            checks++;
            if (instr_count !== 32'd0) begin
                errors++;
                $display("FAIL reset_count got=%0d exp=0", instr_count);
            end
        end
        clear = 1'b0;
        model_count = 32'd0;
        @(negedge clk);
        checks++;
        if (obs !== (M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN)) begin
            errors++;
            $display("FAIL reset_to_t0 got=%h exp=%h", obs, M_RUN | M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
        end
    endtask

    task automatic test_in();      run_instr(5'b10110, -1); endtask
    task automatic test_out();     run_instr(5'b10111, -1); endtask
    task automatic test_add();     run_instr(5'b00011, -1); endtask
    task automatic test_illegal(); run_instr(5'b11111, -1); endtask

    task automatic test_random(input int n);
        logic [4:0] op;
        for (int k = 0; k < n; k++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'b11011) op = 5'b11010;
            run_instr(op, -1);
        end
    endtask

    task automatic test_halt();
        run_instr(5'b11011, -1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (obs !== 32'd0 || instr_count !== model_count) begin
                errors++;
                $display("FAIL halt_hold cyc=%0d got=%h/%0d exp=%h/%0d", i, obs, instr_count, 32'd0, model_count);
            end
            ir = $urandom;
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        test_reset();
        run_instr(5'b11010, -1);
        run_instr(5'b00011, 4);
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if (obs !== 32'd0) begin
            errors++;
            $display("FAIL abort_outputs got=%h exp=%h", obs, 32'd0);
        end
        checks++;
        if (instr_count !== 32'd0) begin
            errors++;
            $display("FAIL abort_count got=%0d exp=0", instr_count);
        end
        @(negedge clk);
        clear = 1'b0;
        model_count = 32'd0;
        @(negedge clk);
        run_instr(5'b01010, -1);
        run_instr(5'b10001, -1);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_in();
        test_out();
        test_add();
        test_illegal();
        test_random(150);
        test_halt();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired sequencer that drives the datapath's one-hot control strobes. It steps through instruction fetch (T0–T2), then decodes IR[31:27] and executes one of the supported instruction classes: reg-reg ALU, unary ALU, in, out, mfhi, mflo, nop and halt. It sits directly upstream of `Datapath`. It replaces hand-sequenced control and connects name-for-name to the datapath control ports.

## Interface
- No parameters.
- `clk`  input  1  system clock, rising-edge.
- `clear`  input  1  asynchronous, active-high reset; same net as the datapath `clear`.
- `IR`  input  32  instruction register contents from the datapath; only [31:27] are used.
- `PCout, Zlowout, MDRout, HIout, LOout, InPortOut`  output  1 each  bus-source selects; at most one high per cycle.
- `MARin, Zin, PCin, MDRin, IRin, Yin, Rin, OutPort`  output  1 each  register load enables.
- `Gra, Grb, Grc, Rout`  output  1 each  register-field select and general-register drive.
- `IncPC, Read`  output  1 each  ALU PC+4 mode and memory read.
- `ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT`  output  1 each  ALU op selects; at most one high.
- `run`  output  1  high in every state except RST and HALT.
- `illegal`  output  1  one-cycle pulse in T3 when the opcode is unsupported.
- `instr_count`  output  32  number of instructions completed since reset.

## Operation
- States: RST, T0, T1, T2, T3, T4, T5, HALT. Outputs are Moore, decoded from the state plus the latched IR[31:27].
- Reset: while `clear` is high, state = RST, all outputs = 0, `instr_count` = 0. First rising edge after release goes RST→T0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin. IR is valid from T3 onward.
- Opcodes:
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010
  - neg 10000, not 10001
  - in 10110, out 10111, mfhi 11000, mflo 11001, nop 11010, halt 11011
- Reg-reg ALU:
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, op select, Zin.
  - T5: Zlowout, Gra, Rin. Then →T0.
- Unary (neg/not):
  - T3: Grb, Rout, op select, Zin.
  - T4: Zlowout, Gra, Rin. Then →T0.
- in: T3: InPortOut, Gra, Rin. Then →T0.
- out: T3: Gra, Rout, OutPort. Then →T0.
- mfhi / mflo: T3: HIout (or LOout), Gra, Rin. Then →T0.
- nop: T3 asserts nothing, then →T0.
- Unsupported opcode: T3 asserts only `illegal`, then →T0; it is otherwise handled as nop.
- halt: T3 asserts nothing, then →HALT. HALT holds all outputs 0 and stays there until `clear`.
- `instr_count` increments by 1 on the edge that leaves the final execute state of every instruction:
  - includes nop and illegal opcodes;
  - includes halt, on its T3→HALT edge;
  - wraps from FFFFFFFF to 0.
- `clear` asserted in any state, mid-instruction included, aborts immediately to RST with outputs 0. No partial register write completes after the asynchronous reset.

## Timing
- CPI: reg-reg 6; unary 5; in, out, mfhi, mflo 4; nop, illegal and halt 4.
- Every strobe is high for exactly one full clock period, aligned to the state register. Datapath registers capture on the rising edge that ends the state.
- Opcode is decoded only in T3 and is held unchanged through T4 and T5 of the same instruction.
- Exactly one bus-source select is high in any cycle that drives the bus, except nop, illegal, HALT and RST, where none is.

## Test plan
- **Reset:** `clear` high for 2 cycles, then low.
  - During `clear`: all outputs 0, `run` = 0.
  - The next edge enters T0 with PCout = MARin = IncPC = Zin = 1.
- **in R1:** InPort holds 0x55; IR = 0xB0800000.
  - T3 asserts InPortOut, Gra, Rin; R1 = 0x55 after that edge.
  - `instr_count` = 1 after 4 cycles.
- **out R1:** R1 = 0x55; IR = 0xB8800000.
  - T3 asserts Gra, Rout, OutPort; OutPortOut = 0x55.
  - Next state is T0.
- **add R3,R1,R2:** R1 = 5, R2 = 7.
  - T3, T4 and T5 strobes match Operation; ADD is high only in T4.
  - R3 = 12 after T5; total 6 cycles.
- **Unsupported opcode 11111:**
  - `illegal` is high for exactly 1 cycle in T3; no Rin or Rout is asserted.
  - `instr_count` increments.
- **halt, then reset mid-add:**
  - After halt: `run` = 0 and the controller stays in HALT for 20 cycles.
  - `clear` pulsed during T4 of an add: outputs are 0 at once, R3 is unchanged, and `instr_count` = 0.
